// File: rtl/fp_subtractor_seq.sv
// fp_subtractor_seq: multi-cycle IEEE-754 single-precision subtractor, result = a - b.
// Define FP_SUB_ROUND_EN for a round-to-nearest-even ROUND stage; default truncates.
module fp_subtractor_seq #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   out_valid,
    input  logic                   out_ready
);
    localparam int unsigned FP_W  = 1 + EXP_W + MAN_W;
    localparam int unsigned MAG_W = MAN_W + 5;      // carry, hidden, fraction, G/R/S
    localparam int unsigned HID   = MAN_W + 3;
    localparam logic [EXP_W-1:0] EXP_MAX  = '1;
    localparam logic [EXP_W-1:0] BIG_DIFF = EXP_W'(MAN_W + 3);

    typedef enum logic [2:0] {IDLE, ALIGN, OP, NORM, ROUND, DONE} state_t;

    state_t             state, state_d;
    logic               sa, sb, sr, sa_d, sb_d, sr_d;
    logic [EXP_W-1:0]   ea, eb, er, ea_d, eb_d, er_d;
    logic [MAG_W-1:0]   ma, mb, mr, ma_d, mb_d, mr_d;
    logic [FP_W-1:0]    result_d;
    logic               out_valid_d, in_ready_d;

    logic [EXP_W-1:0]   a_exp, b_exp;
    logic               a_small, big;
    logic [EXP_W-1:0]   sm_e, lg_e, diff, sh_e;
    logic [MAG_W-1:0]   sm_m, sh_m, op_sum;
    logic               op_sign;

    assign a_exp = a[MAN_W +: EXP_W];
    assign b_exp = b[MAN_W +: EXP_W];

    // One alignment step on the smaller-exponent operand, plus the OP-stage magnitude result.
    always_comb begin
        a_small = (ea < eb);
        sm_m    = a_small ? ma : mb;
        sm_e    = a_small ? ea : eb;
        lg_e    = a_small ? eb : ea;
        diff    = lg_e - sm_e;
        big     = (diff >= BIG_DIFF);
        sh_m    = big ? {{(MAG_W-1){1'b0}}, |sm_m}
                      : {1'b0, sm_m[MAG_W-1:2], |sm_m[1:0]};
        sh_e    = big ? lg_e : sm_e + 1'b1;
        if (sa == sb) begin
            op_sum  = ma + mb;
            op_sign = sa;
        end else if (ma >= mb) begin
            op_sum  = ma - mb;
            op_sign = sa;
        end else begin
            op_sum  = mb - ma;
            op_sign = sb;
        end
    end

`ifdef FP_SUB_ROUND_EN
    logic               rnd_up;
    logic [MAN_W+1:0]   rnd_sum;

    always_comb begin
        rnd_up  = mr[2] & (mr[1] | mr[0] | mr[3]);
        rnd_sum = {1'b0, mr[HID:3]} + (MAN_W+2)'(rnd_up);
    end
`endif

    always_comb begin
        state_d     = state;
        sa_d        = sa;
        sb_d        = sb;
        sr_d        = sr;
        ea_d        = ea;
        eb_d        = eb;
        er_d        = er;
        ma_d        = ma;
        mb_d        = mb;
        mr_d        = mr;
        result_d    = result;
        out_valid_d = out_valid;
        in_ready_d  = in_ready;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    sa_d       = a[FP_W-1];
                    sb_d       = ~b[FP_W-1];
                    ea_d       = a_exp;
                    eb_d       = b_exp;
                    ma_d       = (a_exp == '0) ? '0 : {2'b01, a[MAN_W-1:0], 3'b000};
                    mb_d       = (b_exp == '0) ? '0 : {2'b01, b[MAN_W-1:0], 3'b000};
                    in_ready_d = 1'b0;
                    if (a_exp == '0 && b_exp == '0) begin
                        result_d    = '0;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        state_d = ALIGN;
                    end
                end
            end
            ALIGN: begin
                if (ea == eb) begin
                    state_d = OP;
                end else begin
                    if (a_small) begin
                        ma_d = sh_m;
                        ea_d = sh_e;
                    end else begin
                        mb_d = sh_m;
                        eb_d = sh_e;
                    end
                    if (big || diff == EXP_W'(1)) state_d = OP;
                end
            end
            OP: begin
                mr_d = op_sum;
                sr_d = op_sign;
                er_d = ea;
                if (op_sum == '0) begin
                    result_d    = '0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    state_d = NORM;
                end
            end
            NORM: begin
                if (mr[MAG_W-1]) begin
                    if (er == EXP_MAX - 1'b1) begin
                        result_d    = {sr, EXP_MAX, {MAN_W{1'b0}}};
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        mr_d = {1'b0, mr[MAG_W-1:2], |mr[1:0]};
                        er_d = er + 1'b1;
                    end
                end else if (!mr[HID]) begin
                    if (er == EXP_W'(1)) begin
                        result_d    = '0;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        mr_d = {mr[MAG_W-2:0], 1'b0};
                        er_d = er - 1'b1;
                    end
                end else begin
`ifdef FP_SUB_ROUND_EN
                    state_d = ROUND;
`else
                    result_d    = {sr, er, mr[MAN_W+2:3]};
                    out_valid_d = 1'b1;
                    state_d     = DONE;
`endif
                end
            end
`ifdef FP_SUB_ROUND_EN
            ROUND: begin
                // Rounding up 1.111..1 carries into a new integer bit: renormalise by one.
                if (rnd_sum[MAN_W+1]) begin
                    if (er == EXP_MAX - 1'b1) result_d = {sr, EXP_MAX, {MAN_W{1'b0}}};
                    else                      result_d = {sr, er + 1'b1, rnd_sum[MAN_W:1]};
                end else begin
                    result_d = {sr, er, rnd_sum[MAN_W-1:0]};
                end
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
`endif
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sa        <= 1'b0;
            sb        <= 1'b0;
            sr        <= 1'b0;
            ea        <= '0;
            eb        <= '0;
            er        <= '0;
            ma        <= '0;
            mb        <= '0;
            mr        <= '0;
            result    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= state_d;
            sa        <= sa_d;
            sb        <= sb_d;
            sr        <= sr_d;
            ea        <= ea_d;
            eb        <= eb_d;
            er        <= er_d;
            ma        <= ma_d;
            mb        <= mb_d;
            mr        <= mr_d;
            result    <= result_d;
            out_valid <= out_valid_d;
            in_ready  <= in_ready_d;
        end
    end
endmodule

// File: tb/tb_fp_subtractor_seq.sv
// Self-checking bench for fp_subtractor_seq: directed vectors, handshake/stall and
// reset-abort checks, then random operands against an arithmetic reference model.
module tb_fp_subtractor_seq;
`ifdef FP_SUB_ROUND_EN
    localparam int ROUND_EN = 1;
`else
    localparam int ROUND_EN = 0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] a, b, result;
    logic        in_valid, in_ready, out_valid, out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    fp_subtractor_seq dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .result    (result),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Right shift by d with every shifted-out bit ORed into bit 0.
    function automatic longint align_mag(input longint m, input int d);
        if (d >= 26) return (m != 0) ? 64'd1 : 64'd0;
        return (m >> d) | (((m & ((64'd1 << d) - 1)) != 0) ? 64'd1 : 64'd0);
    endfunction

    // Reference a - b on integer magnitudes scaled by 2^26 relative to the hidden bit.
    function automatic logic [31:0] ref_sub(input logic [31:0] x, input logic [31:0] y);
        longint ma, mb, m, m24;
        int     ea, eb, e;
        logic   sa, sb, s;
        sa = x[31];
        sb = ~y[31];
        ea = int'(x[30:23]);
        eb = int'(y[30:23]);
        ma = (ea == 0) ? 64'd0 : ((64'd1 << 26) + (longint'(x[22:0]) << 3));
        mb = (eb == 0) ? 64'd0 : ((64'd1 << 26) + (longint'(y[22:0]) << 3));
        if (ea == 0 && eb == 0) return 32'h0;
        if (ea >= eb) begin
            mb = align_mag(mb, ea - eb);
            e  = ea;
        end else begin
            ma = align_mag(ma, eb - ea);
            e  = eb;
        end
        if (sa == sb) begin
            m = ma + mb; s = sa;
        end else if (ma >= mb) begin
            m = ma - mb; s = sa;
        end else begin
            m = mb - ma; s = sb;
        end
        if (m == 0) return 32'h0;
        if (m >= (64'd1 << 27)) begin
            m = (m >> 1) | (m & 64'd1);
            e++;
            if (e >= 255) return {s, 8'hFF, 23'h0};
        end
        while (m < (64'd1 << 26)) begin
            m = m << 1;
            e--;
            if (e <= 0) return 32'h0;
        end
        m24 = m >> 3;
        if (ROUND_EN != 0) begin
            if (m[2] && (m[1] || m[0] || m[3])) m24++;
            if (m24 >= (64'd1 << 24)) begin
                m24 = m24 >> 1;
                e++;
                if (e >= 255) return {s, 8'hFF, 23'h0};
            end
        end
        return {s, 8'(e), m24[22:0]};
    endfunction

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check_eq("out_valid_seen", 32'(out_valid), 32'd1);
    endtask

    // Full transaction: accept, wait for result, hand it off.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] r, output int lat);
        @(negedge clk);
        check_eq("in_ready_idle", 32'(in_ready), 32'd1);
        a = x; b = y; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(lat);
        r = result;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("released_valid", 32'(out_valid), 32'd0);
    endtask

    task automatic directed(input string tag, input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] exp);
        logic [31:0] r;
        int lat;
        run_op(x, y, r, lat);
        check_eq(tag, r, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r, held, x, y;
        int lat, ea, eb;

        rst = 1'b1; a = '0; b = '0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_result", result, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        run_op(32'h40400000, 32'h3F800000, r, lat);
        check_eq("3_minus_1", r, 32'h40000000);
        check_eq("lat_3_minus_1", 32'(lat), 32'(4 + ROUND_EN));
        directed("exact_cancel", 32'h3F800000, 32'h3F800000, 32'h00000000);
        directed("carry_path", 32'h3F800000, 32'hC0000000, 32'h40400000);
        directed("guard_bit", 32'h3F800000, 32'h3F7FFFFF, 32'h33800000);
        directed("round_vec", 32'h3F800000, 32'hB4400000,
                 (ROUND_EN != 0) ? 32'h3F800002 : 32'h3F800001);
        directed("both_zero", 32'h00000000, 32'h80000000, 32'h00000000);
        directed("zero_minus_one", 32'h00000000, 32'h3F800000, 32'hBF800000);
        directed("denorm_flush", 32'h00000005, 32'h3F800000, 32'hBF800000);
        directed("overflow_inf", 32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000);
        directed("underflow_zero", 32'h00800001, 32'h00800000, 32'h00000000);
        directed("sticky_only", 32'h4D000000, 32'h3F800000, ref_sub(32'h4D000000, 32'h3F800000));

        // Stall in DONE while new operands are offered.
        @(negedge clk);
        a = 32'h40400000; b = 32'h3F800000; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(lat);
        held = result;
        check_eq("stall_first", held, 32'h40000000);
        a = 32'h41200000; b = 32'h40A00000; in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_eq("stall_valid", 32'(out_valid), 32'd1);
            check_eq("stall_in_ready", 32'(in_ready), 32'd0);
            check_eq("stall_result", result, held);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b0;
        check_eq("stall_release_valid", 32'(out_valid), 32'd0);
        check_eq("stall_release_ready", 32'(in_ready), 32'd1);
        directed("after_stall", 32'h41200000, 32'h40A00000, 32'h40A00000);

        // Asynchronous reset while still aligning.
        @(negedge clk);
        a = 32'h4B000000; b = 32'h3F800000; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("abort_out_valid", 32'(out_valid), 32'd0);
        check_eq("abort_in_ready", 32'(in_ready), 32'd1);
        check_eq("abort_result", result, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) begin
            @(negedge clk);
            check_eq("abort_no_result", 32'(out_valid), 32'd0);
        end
        directed("rerun_after_abort", 32'h4B000000, 32'h3F800000, 32'h4AFFFFFE);

        for (int i = 0; i < 300; i++) begin
            ea = int'($urandom_range(254, 0));
            case ($urandom_range(3, 0))
                0:       eb = int'($urandom_range(254, 0));
                1:       eb = ea;
                default: eb = ea + int'($urandom_range(6, 0)) - 3;
            endcase
            if (eb < 0)   eb = 0;
            if (eb > 254) eb = 254;
            x = {1'($urandom), 8'(ea), 23'($urandom)};
            y = {1'($urandom), 8'(eb), 23'($urandom)};
            if (eb == ea && $urandom_range(1, 0) == 1)
                y[22:0] = x[22:0] ^ 23'($urandom_range(15, 0));
            run_op(x, y, r, lat);
            check_eq($sformatf("rand a=%08h b=%08h", x, y), r, ref_sub(x, y));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
